led_pattern_ctrl: RTL and testbench

- Sequencer for the 8-LED display: steps one of four LED patterns on each 1 Hz tick and drives led[7:0].
- Sits between the 1 Hz tick divider and the LED pins, in place of a fixed-pattern runner.
- Handles debounced "next mode" and "pause" buttons, plus an optional auto-advance through the modes.

---
 rtl/led_pattern_ctrl.sv | 158 +++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// 8-LED pattern sequencer: four patterns stepped by a 1 Hz tick, with debounced
// "next mode" / "pause" buttons and optional auto-advance after REPEAT sweeps.

module led_pattern_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rs,
  input  logic raw_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          meta_q, sync_q, level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchronizer, debounced level and stability counter
  always_ff @(posedge clk) begin
    if (rs) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive differing samples
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Press edge only; release produces nothing
  assign pulse_o = sync_q & ~level_q & (cnt_q == CNT_MAX);
endmodule

module led_pattern_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int REPEAT    = 2
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       tick,
  input  logic       btn_next,
  input  logic       btn_pause,
  input  logic       auto,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       paused,
  output logic       sweep_done
);
  localparam int SW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [SW-1:0] SW_MAX = SW'(REPEAT - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_PAUSE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [2:0]    step_q, step_d;
  logic [SW-1:0] swcnt_q, swcnt_d;
  logic          sdone_q, sdone_d;
  logic          next_p, pause_p;
  logic [7:0]    led_s;

  led_pattern_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .clk(clk), .rs(rs), .raw_i(btn_next), .pulse_o(next_p)
  );

  led_pattern_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk(clk), .rs(rs), .raw_i(btn_pause), .pulse_o(pause_p)
  );

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rs) begin
      state_q <= ST_RUN;
      mode_q  <= 2'd0;
      step_q  <= 3'd0;
      swcnt_q <= '0;
      sdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      swcnt_q <= swcnt_d;
      sdone_q <= sdone_d;
    end
  end

  // Next state: any button pulse swallows a tick arriving in the same cycle
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    step_d  = step_q;
    swcnt_d = swcnt_q;
    sdone_d = 1'b0;
    if (pause_p) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end else begin
      state_d = state_q;
    end
    if (next_p) begin
      mode_d  = mode_q + 2'd1;
      step_d  = 3'd0;
      swcnt_d = '0;
    end else if (!pause_p && (state_q == ST_RUN) && tick) begin
      step_d = step_q + 3'd1;
      if (step_q == 3'd7) begin
        sdone_d = 1'b1;
        if (auto && (swcnt_q == SW_MAX)) begin
          mode_d  = mode_q + 2'd1;
          swcnt_d = '0;
        end else if (swcnt_q != SW_MAX) begin
          swcnt_d = swcnt_q + SW'(1);
        end else begin
          swcnt_d = swcnt_q;
        end
      end else begin
        sdone_d = 1'b0;
      end
    end else begin
      step_d = step_q;
    end
  end

  // Pattern decode straight from registered mode/step
  always_comb begin
    led_s = 8'h01;
    case (mode_q)
      2'd0:    led_s = 8'h01 << step_q;
      2'd1:    led_s = (8'h03 << step_q) | (8'h03 >> (4'd8 - {1'b0, step_q}));
      2'd2:    led_s = 8'hFF >> (3'd7 - step_q);
      2'd3:    led_s = step_q[0] ? 8'h00 : 8'hFF;
      default: led_s = 8'h01;
    endcase
  end

  assign led        = led_s;
  assign mode       = mode_q;
  assign paused     = (state_q == ST_PAUSE);
  assign sweep_done = sdone_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: tick/auto vector table plus button,
// pause, same-cycle priority and reset sequences.

module tb_led_pattern_ctrl;
  logic       clk = 1'b0;
  logic       rs = 1'b1, tick = 1'b0, btn_next = 1'b0, btn_pause = 1'b0, auto = 1'b0;
  logic [7:0] led;
  logic [1:0] mode;
  logic       paused, sweep_done;
  int         n_cmp = 0;
  int         n_bad = 0;

  led_pattern_ctrl #(.DB_CYCLES(4), .REPEAT(2)) dut (
    .clk(clk), .rs(rs), .tick(tick), .btn_next(btn_next), .btn_pause(btn_pause),
    .auto(auto), .led(led), .mode(mode), .paused(paused), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       t;
    logic       a;
    logic [7:0] led;
    logic [1:0] mode;
    logic       sd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(logic r, logic t, logic a, logic [7:0] l, logic [1:0] m, logic s);
    vec_t x;
    x.r = r; x.t = t; x.a = a; x.led = l; x.mode = m; x.sd = s;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, return 1 time unit after the rising edge.
  task automatic apply(input logic r, input logic t, input logic a, input logic bn, input logic bp);
    @(negedge clk);
    rs = r; tick = t; auto = a; btn_next = bn; btn_pause = bp;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [7:0] l, input logic [1:0] m,
                         input logic p, input logic s);
    chk({nm, ".led"}, led, l);
    chk({nm, ".mode"}, {6'd0, mode}, {6'd0, m});
    chk({nm, ".paused"}, {7'd0, paused}, {7'd0, p});
    chk({nm, ".sweep_done"}, {7'd0, sweep_done}, {7'd0, s});
  endtask

  initial begin
    // Mode0 with auto=0: two sweeps (sweep count saturates), then a third with auto=1
    vt.push_back(v(0,1,0,8'h02,2'd0,1'b0)); vt.push_back(v(0,1,0,8'h04,2'd0,1'b0));
    vt.push_back(v(0,1,0,8'h08,2'd0,1'b0)); vt.push_back(v(0,1,0,8'h10,2'd0,1'b0));
    vt.push_back(v(0,1,0,8'h20,2'd0,1'b0)); vt.push_back(v(0,1,0,8'h40,2'd0,1'b0));
    vt.push_back(v(0,1,0,8'h80,2'd0,1'b0)); vt.push_back(v(0,1,0,8'h01,2'd0,1'b1));
    vt.push_back(v(0,0,0,8'h01,2'd0,1'b0));
    vt.push_back(v(0,1,0,8'h02,2'd0,1'b0)); vt.push_back(v(0,1,0,8'h04,2'd0,1'b0));
    vt.push_back(v(0,1,0,8'h08,2'd0,1'b0)); vt.push_back(v(0,1,0,8'h10,2'd0,1'b0));
    vt.push_back(v(0,1,0,8'h20,2'd0,1'b0)); vt.push_back(v(0,1,0,8'h40,2'd0,1'b0));
    vt.push_back(v(0,1,0,8'h80,2'd0,1'b0)); vt.push_back(v(0,1,0,8'h01,2'd0,1'b1));
    vt.push_back(v(0,1,1,8'h02,2'd0,1'b0)); vt.push_back(v(0,1,1,8'h04,2'd0,1'b0));
    vt.push_back(v(0,1,1,8'h08,2'd0,1'b0)); vt.push_back(v(0,1,1,8'h10,2'd0,1'b0));
    vt.push_back(v(0,1,1,8'h20,2'd0,1'b0)); vt.push_back(v(0,1,1,8'h40,2'd0,1'b0));
    vt.push_back(v(0,1,1,8'h80,2'd0,1'b0)); vt.push_back(v(0,1,1,8'h03,2'd1,1'b1));
    // Mode1 rotation through step7 (8'h81) and wrap; count was cleared so no advance
    vt.push_back(v(0,1,1,8'h06,2'd1,1'b0)); vt.push_back(v(0,1,1,8'h0C,2'd1,1'b0));
    vt.push_back(v(0,1,1,8'h18,2'd1,1'b0)); vt.push_back(v(0,1,1,8'h30,2'd1,1'b0));
    vt.push_back(v(0,1,1,8'h60,2'd1,1'b0)); vt.push_back(v(0,1,1,8'hC0,2'd1,1'b0));
    vt.push_back(v(0,1,1,8'h81,2'd1,1'b0)); vt.push_back(v(0,1,1,8'h03,2'd1,1'b1));
    vt.push_back(v(0,0,1,8'h03,2'd1,1'b0));
    // Reset with tick high, then auto=1 for 18 ticks (auto dropped mid-sweep)
    vt.push_back(v(1,1,1,8'h01,2'd0,1'b0));
    vt.push_back(v(0,1,1,8'h02,2'd0,1'b0)); vt.push_back(v(0,1,1,8'h04,2'd0,1'b0));
    vt.push_back(v(0,1,1,8'h08,2'd0,1'b0)); vt.push_back(v(0,1,1,8'h10,2'd0,1'b0));
    vt.push_back(v(0,1,1,8'h20,2'd0,1'b0)); vt.push_back(v(0,1,1,8'h40,2'd0,1'b0));
    vt.push_back(v(0,1,1,8'h80,2'd0,1'b0)); vt.push_back(v(0,1,1,8'h01,2'd0,1'b1));
    vt.push_back(v(0,1,0,8'h02,2'd0,1'b0)); vt.push_back(v(0,1,0,8'h04,2'd0,1'b0));
    vt.push_back(v(0,1,0,8'h08,2'd0,1'b0)); vt.push_back(v(0,1,0,8'h10,2'd0,1'b0));
    vt.push_back(v(0,1,1,8'h20,2'd0,1'b0)); vt.push_back(v(0,1,1,8'h40,2'd0,1'b0));
    vt.push_back(v(0,1,1,8'h80,2'd0,1'b0)); vt.push_back(v(0,1,1,8'h03,2'd1,1'b1));
    vt.push_back(v(0,1,1,8'h06,2'd1,1'b0)); vt.push_back(v(0,1,1,8'h0C,2'd1,1'b0));

    apply(1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0);
    chk_all("reset", 8'h01, 2'd0, 1'b0, 1'b0);

    foreach (vt[i]) begin
      apply(vt[i].r, vt[i].t, vt[i].a, 1'b0, 1'b0);
      chk_all($sformatf("vec%0d", i), vt[i].led, vt[i].mode, 1'b0, vt[i].sd);
    end

    // Bouncy next press: 1,0 then stable high; pulse on 6th cycle of stable high
    apply(1, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 0, 0, 1, 0);
    chk("next_early.mode", {6'd0, mode}, 8'd0);
    apply(0, 0, 0, 1, 0);
    chk_all("next_pulse", 8'h03, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) apply(0, 0, 0, 0, 0);
    chk_all("next_single", 8'h03, 2'd1, 1'b0, 1'b0);

    // Pause: ticks frozen, second press resumes
    for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 1);
    chk("pause_on", {7'd0, paused}, 8'd1);
    for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 1, 0, 0, 0);
    chk_all("pause_hold", 8'h03, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 1);
    chk("pause_off", {7'd0, paused}, 8'd0);
    for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0);
    chk_all("resume_tick", 8'h06, 2'd1, 1'b0, 1'b0);

    // Reach mode2 step5, then next_p coincides with a tick
    for (int i = 0; i < 8; i++) apply(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 0);
    chk_all("mode2", 8'h01, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) apply(0, 1, 0, 0, 0);
    chk("mode2_step5", led, 8'h3F);
    for (int i = 0; i < 5; i++) apply(0, 0, 0, 1, 0);
    apply(0, 1, 0, 1, 0);
    chk_all("next_vs_tick", 8'hFF, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 0);
    chk_all("next_release", 8'hFF, 2'd3, 1'b0, 1'b0);
    apply(0, 1, 0, 0, 0); chk("blink1", led, 8'h00);
    apply(0, 1, 0, 0, 0); chk("blink2", led, 8'hFF);
    apply(0, 1, 0, 0, 0); chk("blink3", led, 8'h00);
    apply(0, 1, 0, 0, 0); chk("blink4", led, 8'hFF);

    // Reset while paused at mode3 step4
    for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 1);
    chk("pause_m3", {7'd0, paused}, 8'd1);
    for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0);
    chk_all("reset_paused", 8'h01, 2'd0, 1'b0, 1'b0);
    apply(0, 1, 0, 0, 0);
    chk_all("after_reset_tick", 8'h02, 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
